// File: rtl/cpu_muldiv.sv
// Iterative RV32M multiply/divide unit: radix-2, one iteration per clock.
// Multiply is shift-add and divide is restoring. Both run on operand
// magnitudes in a shared 64-bit accumulator, and the sign is applied when
// the unit moves into DONE.
module cpu_muldiv #(
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t      state;
  logic [5:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] mag_a, mag_b;
  logic [63:0] acc;      // mul: {partial hi, multiplier}; div: {rem, dividend/quotient}
  logic        neg_q;    // negate the final product / quotient / remainder
  logic        div0_q;
  logic        ovf_q;

  // ---------------- accept-time decode of the incoming request ----------------
  logic        a_sgn, b_sgn;
  logic [31:0] mag_a_in, mag_b_in;
  logic        neg_in, div0_in, ovf_in;

  // Operand signedness, magnitudes, result sign and special-case flags
  always_comb begin
    a_sgn    = src_a[31] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
    b_sgn    = src_b[31] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
    mag_a_in = a_sgn ? (~src_a + 32'd1) : src_a;
    mag_b_in = b_sgn ? (~src_b + 32'd1) : src_b;
    div0_in  = op[2] & (src_b == 32'd0);
    ovf_in   = op[2] & ~op[0] & (src_a == 32'h8000_0000) & (src_b == 32'hFFFF_FFFF);
    // A divide by zero must give an all-ones quotient regardless of the
    // dividend sign, so the quotient sign is suppressed in that case.
    if (op[2])
      neg_in = op[1] ? a_sgn : ((a_sgn ^ b_sgn) & ~div0_in);
    else
      neg_in = a_sgn ^ b_sgn;
  end

  // ---------------- one radix-2 iteration ----------------
  logic [32:0] mul_sum;
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] acc_nx;

  // Next accumulator value for the current op class
  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    div_sh  = acc[63:31];
    div_ge  = (div_sh >= {1'b0, mag_b});
    // The difference is below mag_b whenever it is kept, so 32 bits suffice.
    div_sub = div_sh[31:0] - mag_b;
    if (op_q[2])
      acc_nx = div_ge ? {div_sub, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    else
      acc_nx = {mul_sum, acc[31:1]};
  end

  // ---------------- final result formation ----------------
  logic [63:0] prod_s;
  logic [31:0] qr, qr_s;
  logic [31:0] fin_res;
  logic [31:0] spec_res;
  logic        fast_hit;

  // Sign fix-up and output selection on the post-iteration accumulator
  always_comb begin
    prod_s = neg_q ? (~acc_nx + 64'd1) : acc_nx;
    qr     = op_q[1] ? acc_nx[63:32] : acc_nx[31:0];
    qr_s   = neg_q ? (~qr + 32'd1) : qr;
    case (op_q)
      OP_MUL:                    fin_res = prod_s[31:0];
      3'b001, 3'b010, 3'b011:    fin_res = prod_s[63:32];
      default:                   fin_res = qr_s;
    endcase
    // Early-exit values; the remainder of x/0 is x, rebuilt from its magnitude
    if (div0_q)
      spec_res = op_q[1] ? (neg_q ? (~mag_a + 32'd1) : mag_a) : 32'hFFFF_FFFF;
    else
      spec_res = op_q[1] ? 32'd0 : 32'h8000_0000;
    fast_hit = FAST_SPECIAL & (div0_q | ovf_q);
  end

  // Control FSM with operand latching, iteration and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= 6'd0;
      op_q   <= 3'd0;
      mag_a  <= 32'd0;
      mag_b  <= 32'd0;
      acc    <= 64'd0;
      neg_q  <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      valid  <= 1'b0;
      result <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (start && !flush) begin
            state  <= RUN;
            cnt    <= 6'd0;
            op_q   <= op;
            mag_a  <= mag_a_in;
            mag_b  <= mag_b_in;
            neg_q  <= neg_in;
            div0_q <= div0_in;
            ovf_q  <= ovf_in;
            acc    <= op[2] ? {32'd0, mag_a_in} : {32'd0, mag_b_in};
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else if (fast_hit) begin
            state  <= DONE;
            valid  <= 1'b1;
            result <= spec_res;
          end else begin
            acc <= acc_nx;
            cnt <= cnt + 6'd1;
            if (cnt == 6'd31) begin
              state  <= DONE;
              valid  <= 1'b1;
              result <= fin_res;
            end
          end
        end
        DONE: begin
          valid <= 1'b0;
          state <= IDLE;
        end
        default: begin
          valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

endmodule

// File: tb/tb_cpu_muldiv.sv
// Scoreboard bench for cpu_muldiv: two instances (early special exit on and
// off) run the same stimulus; expected results are queued at issue and
// popped whenever an instance raises valid.
module tb_cpu_muldiv;

  logic        clk = 1'b0;
  logic        rst_n, start, flush;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        rdy1, bsy1, v1, rdy0, bsy0, v0;
  logic [31:0] r1, r0;

  int checks = 0;
  int fails  = 0;
  logic [31:0] q1[$];
  logic [31:0] q0[$];
  logic [31:0] last_res = 32'd0;

  always #5 clk = ~clk;

  cpu_muldiv #(.FAST_SPECIAL(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .ready(rdy1), .busy(bsy1), .valid(v1), .result(r1));

  cpu_muldiv #(.FAST_SPECIAL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a),
    .src_b(src_b), .flush(flush), .ready(rdy0), .busy(bsy0), .valid(v0), .result(r0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model of the RV32M operations
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    logic signed [31:0] a32, b32;
    logic ovf;
    sa = {{32{a[31]}}, a};  sb = {{32{b[31]}}, b};
    za = {32'd0, a};        zb = {32'd0, b};
    a32 = a; b32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = za * zb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * zb; return p[63:32]; end
      3'd3: begin p = za * zb; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(a32 / b32));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : (ovf ? 32'd0 : 32'(a32 % b32));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int fast_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 2;
    return 33;
  endfunction

  // Scoreboard: every valid pulse must match the oldest outstanding result
  always @(negedge clk) begin
    if (v1) begin
      if (q1.size() == 0) chk("spurious_valid_fast", {31'd0, v1}, 32'd0);
      else chk("result_fast", r1, q1.pop_front());
    end
    if (v0) begin
      if (q0.size() == 0) chk("spurious_valid_slow", {31'd0, v0}, 32'd0);
      else chk("result_slow", r0, q0.pop_front());
    end
  end

  // Issue one op. abort: 0 none, 1 flush at edge abort_k, 2 reset at abort_k.
  // poke: re-pulse start with fresh operands before edge E<poke>.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int poke, input int abort, input int abort_k);
    logic [31:0] e;
    int l1, l0, lat1;
    bit bad;
    e = ref_op(o, a, b);
    lat1 = fast_lat(o, a, b);
    l1 = 0; l0 = 0; bad = 0;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (abort == 0) begin q1.push_back(e); q0.push_back(e); end
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (v1 && l1 == 0) l1 = k;
      if (v0 && l0 == 0) l0 = k;
      if (abort != 0 && k == abort_k + 1) break;
      if ((l1 == 0 && rdy1) || (l0 == 0 && rdy0)) bad = 1;
      if (abort == 0 && l1 != 0 && l0 != 0) break;
      start = (k == poke);
      flush = (abort == 1 && k == abort_k);
      rst_n = !(abort == 2 && k == abort_k);
      src_a = $urandom; src_b = $urandom; op = 3'($urandom);
    end
    start = 1'b0; flush = 1'b0; rst_n = 1'b1;
    if (abort == 0) begin
      chk("latency_fast", l1, lat1);
      chk("latency_slow", l0, 33);
      chk("ready_low_while_busy", {31'd0, bad}, 32'd0);
      last_res = e;
    end else if (abort == 1) begin
      chk("flush_no_valid", l1 + l0, 0);
      chk("flush_ready", {30'd0, rdy1, rdy0}, 32'd3);
      chk("flush_result_fast", r1, last_res);
      chk("flush_result_slow", r0, last_res);
    end else begin
      chk("rst_ctrl", {26'd0, rdy1, bsy1, v1, rdy0, bsy0, v0}, 32'b100100);
      chk("rst_result", r1 | r0, 32'd0);
      last_res = 32'd0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {26'd0, rdy1, bsy1, v1, rdy0, bsy0, v0}, 32'b100100);
    chk("reset_result", r1 | r0, 32'd0);
    rst_n = 1'b1;

    // Multiplies
    do_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0, 0, 0);
    chk("mul_value", last_res, 32'hFFFF_FFEB);
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0, 0);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    // Divides
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0, 0, 0);
    do_op(3'd5, 32'd100, 32'd7, 0, 0, 0);
    do_op(3'd7, 32'd100, 32'd7, 0, 0, 0);
    // Special cases: early exit on one instance, full latency on the other
    do_op(3'd4, 32'd5, 32'd0, 0, 0, 0);
    do_op(3'd7, 32'd5, 32'd0, 0, 0, 0);
    do_op(3'd6, 32'hFFFF_FFFB, 32'd0, 0, 0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0);
    // Start while busy is ignored
    do_op(3'd5, 32'd100, 32'd7, 5, 0, 0);
    chk("ignored_start_value", last_res, 32'd14);
    // Flush mid-multiply
    do_op(3'd0, 32'd3, 32'd4, 0, 1, 10);
    // Reset mid-divide
    do_op(3'd4, 32'd1000, 32'd3, 0, 2, 10);
    // Flush + start together in IDLE
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; src_a = 32'd9; src_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_ready", {30'd0, rdy1, rdy0}, 32'd3);
    repeat (3) @(negedge clk);
    chk("flush_start_idle", {30'd0, rdy1, rdy0}, 32'd3);
    // Random operations against the model
    for (int i = 0; i < 8; i++)
      do_op(3'($urandom), $urandom, (i == 3) ? 32'd0 : $urandom, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("queue_drained", q1.size() + q0.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
